cpu_sdram_responder: RTL and testbench
======================================

Name: cpu_sdram_responder

Overview:
- Services CPU memory cycles that the address decoder flags as RAM/ROM (ram_rom_memrq), against the shared SDRAM controller's CPU port.
- Uses a toggle req/ack handshake on the SDRAM side.
- Latches the translated address, drops writes to non-writable regions, and returns read data with a one-cycle ready pulse.
- Sits between the V33 bus glue and the SDRAM arbiter; one instance per CPU.

Parameters:
- TIMEOUT, 255: cycles to wait for sdr_ack before forcing completion; 8-bit counter, 1..255.
- FILL_DATA, 16'hFFFF: read data returned on timeout.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_rd  in  1  CPU read strobe; level, held until ready
- mem_wr  in  1  CPU write strobe; level, held until ready
- mem_be  in  2  byte enables {hi,lo}
- mem_din  in  16  CPU write data
- ram_rom_memrq  in  1  decoder select
- writable  in  1  decoder: region accepts writes
- sdr_addr_in  in  25  decoder byte address
- mem_dout  out  16  read data, valid when ready=1
- ready  out  1  one-cycle completion pulse
- timeout_err  out  1  one-cycle pulse on forced completion
- sdr_req  out  1  toggles once per SDRAM request
- sdr_ack  in  1  controller sets equal to sdr_req when the request is done
- sdr_addr  out  25  latched address, bit 0 forced 0
- sdr_wr  out  1  1 = write request
- sdr_be  out  2  latched byte enables
- sdr_wdata  out  16  latched write data
- sdr_rdata  in  16  read data, valid in the cycle sdr_ack==sdr_req first holds

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Rule: sdr_req toggles only while sdr_req==sdr_ack.
- Start condition: ram_rom_memrq & (mem_rd|mem_wr) sampled in IDLE.
- If mem_rd and mem_wr are both high, treat the cycle as a read.
- States: IDLE, BUSY, DONE, RELEASE.
- IDLE, start with write & !writable:
  - next state DONE; no SDRAM request.
  - ready=1 in the following cycle.
- IDLE, other start:
  - latch sdr_addr={sdr_addr_in[24:1],1'b0}, sdr_be, sdr_wdata, sdr_wr=mem_wr&!mem_rd.
  - toggle sdr_req; clear the timeout counter; go BUSY.
- BUSY:
  - sdr_ack==sdr_req: capture sdr_rdata into mem_dout for reads; go DONE.
  - Otherwise, counter==TIMEOUT-1: mem_dout=FILL_DATA for reads; timeout_err=1 for one cycle; go DONE.
  - A late ack after a timeout is absorbed: no new toggle until req==ack, and the IDLE start waits for equality.
- DONE: ready=1 for exactly one cycle; go RELEASE.
- RELEASE: stay until mem_rd|mem_wr are both low, then IDLE. This prevents reissuing a held strobe.
- Minimum latency:
  - SDRAM access: ready two cycles after the cycle in which ack matches.
  - Dropped write: ready two cycles after the start cycle.
- mem_dout holds its last value between reads; writes do not alter it.
- ram_rom_memrq deasserting mid-BUSY is ignored; the access completes.
- Async reset mid-BUSY returns to IDLE with sdr_req=0. The controller must also be reset; this block does not re-handshake.

Optional Feature:
- Macro CPU_READ_CACHE_EN adds a one-word read cache: tag (24 bits), data (16), valid.
- Enabled:
  - Hit: read start with valid & tag==sdr_addr_in[24:1] goes straight to DONE with cached data; no sdr_req toggle.
  - Fill: every completed non-timeout read updates tag/data and sets valid.
  - Invalidate: any accepted write whose address matches the tag clears valid. Dropped writes do not.
  - Reset clears valid.
- Disabled: every read goes to SDRAM; no cache state exists.

Test Plan:
- Read 0x0012344, controller acks after 5 cycles with 0xBEEF -> sdr_req toggles once, sdr_addr=0x0012344, mem_dout=0xBEEF with a single ready pulse, no retoggle while mem_rd is held.
- Write 0xA55A, be=2'b01, writable=1 -> sdr_wr=1, sdr_be=01, sdr_wdata=0xA55A, one ready pulse after ack.
- Write with writable=0 -> no sdr_req change, ready two cycles after start, mem_dout unchanged.
- Controller never acks, TIMEOUT=16 -> timeout_err and ready pulse together, mem_dout=0xFFFF. A later ack is then given and the next read completes normally.
- CPU_READ_CACHE_EN: read X, reread X -> second read has no sdr_req toggle and the same data. Write X then read X -> SDRAM accessed again.
- Assert reset during BUSY -> all outputs 0 next cycle; a new read after release completes correctly.

Source files
------------

// File: rtl/cpu_sdram_responder_if.sv
// CPU bus and SDRAM controller port signals of one responder instance.
// master = bus glue / controller side, slave = responder side.
interface cpu_sdram_responder_if;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  mem_be;
   logic [15:0] mem_din;
   logic        ram_rom_memrq;
   logic        writable;
   logic [24:0] sdr_addr_in;
   logic [15:0] mem_dout;
   logic        ready;
   logic        timeout_err;
   logic        sdr_req;
   logic        sdr_ack;
   logic [24:0] sdr_addr;
   logic        sdr_wr;
   logic [1:0]  sdr_be;
   logic [15:0] sdr_wdata;
   logic [15:0] sdr_rdata;

   modport master (
      output mem_rd, mem_wr, mem_be, mem_din,
      output ram_rom_memrq, writable, sdr_addr_in,
      output sdr_ack, sdr_rdata,
      input  mem_dout, ready, timeout_err,
      input  sdr_req, sdr_addr, sdr_wr, sdr_be, sdr_wdata
   );

   modport slave (
      input  mem_rd, mem_wr, mem_be, mem_din,
      input  ram_rom_memrq, writable, sdr_addr_in,
      input  sdr_ack, sdr_rdata,
      output mem_dout, ready, timeout_err,
      output sdr_req, sdr_addr, sdr_wr, sdr_be, sdr_wdata
   );
endinterface

// File: rtl/cpu_sdram_responder.sv
// CPU RAM/ROM cycle responder on a toggle req/ack SDRAM port.
// Optional one-word read cache: define CPU_READ_CACHE_EN.
module cpu_sdram_responder #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [15:0] FILL_DATA = 16'hFFFF
) (
   input logic                    clk_sys,
   input logic                    reset,
   cpu_sdram_responder_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_to_pend;
   logic        r_req;
   logic [24:0] r_addr;
   logic        r_wr;
   logic [1:0]  r_be;
   logic [15:0] r_wdata;
   logic [15:0] r_dout;
   logic        r_ready;
   logic        r_terr;

   logic        w_start;
   logic        w_sync;
   logic        w_drop;
   logic        w_hit;
   logic [15:0] w_cdata;
   logic        w_issue;
   logic        w_cap;
   logic        w_tmo;
   logic        w_hit_go;
   logic        w_unused;

   assign w_start  = bus.ram_rom_memrq & (bus.mem_rd | bus.mem_wr);
   assign w_sync   = (r_req == bus.sdr_ack);
   assign w_drop   = !bus.mem_rd & !bus.writable;
   assign w_unused = bus.sdr_addr_in[0];

`ifdef CPU_READ_CACHE_EN
   logic        r_cvalid;
   logic [23:0] r_ctag;
   logic [15:0] r_cdata;

   assign w_hit   = bus.mem_rd & r_cvalid &
                    (r_ctag == bus.sdr_addr_in[24:1]);
   assign w_cdata = r_cdata;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_cvalid <= 1'b0;
         r_ctag   <= '0;
         r_cdata  <= '0;
      end else if (w_cap && !r_wr) begin
         r_cvalid <= 1'b1;
         r_ctag   <= r_addr[24:1];
         r_cdata  <= bus.sdr_rdata;
      end else if (w_issue && !bus.mem_rd &&
                   r_ctag == bus.sdr_addr_in[24:1]) begin
         r_cvalid <= 1'b0;
      end
   end
`else
   assign w_hit   = 1'b0;
   assign w_cdata = '0;
`endif

   always_comb begin
      w_next   = r_state;
      w_issue  = 1'b0;
      w_cap    = 1'b0;
      w_tmo    = 1'b0;
      w_hit_go = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_start) begin
               if (w_drop) begin
                  w_next = DONE;
               end else if (w_hit) begin
                  w_next   = DONE;
                  w_hit_go = 1'b1;
               end else if (w_sync) begin
                  // a late ack from a timed-out access must land first
                  w_next  = BUSY;
                  w_issue = 1'b1;
               end
            end
         end
         BUSY: begin
            if (w_sync) begin
               w_cap  = 1'b1;
               w_next = DONE;
            end else if (r_cnt == TMO_LAST) begin
               w_tmo  = 1'b1;
               w_next = DONE;
            end
         end
         DONE: w_next = RELEASE;
         RELEASE: begin
            if (!bus.mem_rd && !bus.mem_wr) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_to_pend <= 1'b0;
         r_req     <= 1'b0;
         r_addr    <= '0;
         r_wr      <= 1'b0;
         r_be      <= '0;
         r_wdata   <= '0;
         r_dout    <= '0;
         r_ready   <= 1'b0;
         r_terr    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (r_state == DONE);
         r_terr  <= (r_state == DONE) & r_to_pend;
         if (w_issue) begin
            r_req   <= ~r_req;
            r_addr  <= {bus.sdr_addr_in[24:1], 1'b0};
            r_wr    <= bus.mem_wr & !bus.mem_rd;
            r_be    <= bus.mem_be;
            r_wdata <= bus.mem_din;
            r_cnt   <= '0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_tmo) r_to_pend <= 1'b1;
         else if (r_state == IDLE) r_to_pend <= 1'b0;
         if (w_cap && !r_wr) r_dout <= bus.sdr_rdata;
         if (w_tmo && !r_wr) r_dout <= FILL_DATA;
         if (w_hit_go) r_dout <= w_cdata;
      end
   end

   assign bus.mem_dout    = r_dout;
   assign bus.ready       = r_ready;
   assign bus.timeout_err = r_terr;
   assign bus.sdr_req     = r_req;
   assign bus.sdr_addr    = r_addr;
   assign bus.sdr_wr      = r_wr;
   assign bus.sdr_be      = r_be;
   assign bus.sdr_wdata   = r_wdata;

endmodule

// File: tb/tb_cpu_sdram_responder.sv
// Directed bench for cpu_sdram_responder (TIMEOUT=16).
// Cache checks follow CPU_READ_CACHE_EN when it is defined.
module tb_cpu_sdram_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_ready = 0;
   int   n0;
   logic exp_req = 1'b0;

   cpu_sdram_responder_if bus ();

   cpu_sdram_responder #(.TIMEOUT(16), .FILL_DATA(16'hFFFF)) dut (
      .clk_sys (clk),
      .reset   (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.ready === 1'b1) n_ready++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_rd(logic [24:0] a);
      bus.ram_rom_memrq = 1'b1;
      bus.mem_rd = 1'b1;
      bus.mem_wr = 1'b0;
      bus.sdr_addr_in = a;
   endtask

   task automatic start_wr(logic [24:0] a, logic [15:0] d,
                           logic [1:0] be, logic w);
      bus.ram_rom_memrq = 1'b1;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b1;
      bus.sdr_addr_in = a;
      bus.mem_din = d;
      bus.mem_be = be;
      bus.writable = w;
   endtask

   task automatic release_bus();
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      bus.ram_rom_memrq = 1'b0;
      step();
      step();
   endtask

   task automatic ack(logic [15:0] d);
      bus.sdr_ack = exp_req;
      bus.sdr_rdata = d;
   endtask

   // read through SDRAM with an immediate ack
   task automatic sdram_read(string tag, logic [24:0] a, logic [15:0] d);
      start_rd(a);
      step();
      exp_req = ~exp_req;
      chk({tag, "_req"}, 32'(bus.sdr_req), 32'(exp_req));
      ack(d);
      step();
      step();
      chk({tag, "_rdy"}, 32'(bus.ready), 32'd1);
      chk({tag, "_dout"}, 32'(bus.mem_dout), 32'(d));
      release_bus();
   endtask

   initial begin
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      bus.mem_be = 2'b00;
      bus.mem_din = 16'h0;
      bus.ram_rom_memrq = 1'b0;
      bus.writable = 1'b0;
      bus.sdr_addr_in = '0;
      bus.sdr_ack = 1'b0;
      bus.sdr_rdata = 16'h0;
      step();
      step();
      chk("rst_dout", 32'(bus.mem_dout), 32'h0);
      chk("rst_rdy", 32'(bus.ready), 32'h0);
      chk("rst_terr", 32'(bus.timeout_err), 32'h0);
      chk("rst_req", 32'(bus.sdr_req), 32'h0);
      chk("rst_addr", 32'(bus.sdr_addr), 32'h0);
      chk("rst_wr", 32'({bus.sdr_wr, bus.sdr_be}), 32'h0);
      chk("rst_wdata", 32'(bus.sdr_wdata), 32'h0);
      rst = 1'b0;
      step();

      // read, ack after 5 cycles, strobe held afterwards
      n0 = n_ready;
      start_rd(25'h0012345);
      step();
      exp_req = 1'b1;
      chk("rd_req", 32'(bus.sdr_req), 32'd1);
      chk("rd_addr", 32'(bus.sdr_addr), 32'h0012344);
      chk("rd_wr", 32'(bus.sdr_wr), 32'd0);
      step(); step(); step(); step();
      chk("rd_wait", 32'(bus.ready), 32'd0);
      ack(16'hBEEF);
      step();
      chk("rd_done_dout", 32'(bus.mem_dout), 32'hBEEF);
      chk("rd_done_rdy", 32'(bus.ready), 32'd0);
      step();
      chk("rd_rdy", 32'(bus.ready), 32'd1);
      bus.sdr_rdata = 16'h0000;
      step(); step(); step(); step();
      chk("rd_hold_req", 32'(bus.sdr_req), 32'd1);
      chk("rd_hold_rdy", 32'(bus.ready), 32'd0);
      chk("rd_pulses", 32'(n_ready - n0), 32'd1);
      release_bus();

      // accepted write
      start_wr(25'h0000100, 16'hA55A, 2'b01, 1'b1);
      step();
      exp_req = 1'b0;
      chk("wr_req", 32'(bus.sdr_req), 32'd0);
      chk("wr_wr", 32'(bus.sdr_wr), 32'd1);
      chk("wr_be", 32'(bus.sdr_be), 32'h1);
      chk("wr_wdata", 32'(bus.sdr_wdata), 32'hA55A);
      ack(16'h1111);
      step();
      step();
      chk("wr_rdy", 32'(bus.ready), 32'd1);
      chk("wr_dout", 32'(bus.mem_dout), 32'hBEEF);
      release_bus();

      // write to a non-writable region
      start_wr(25'h0000200, 16'h1234, 2'b11, 1'b0);
      step();
      chk("drop_req", 32'(bus.sdr_req), 32'd0);
      chk("drop_rdy0", 32'(bus.ready), 32'd0);
      step();
      chk("drop_rdy", 32'(bus.ready), 32'd1);
      chk("drop_dout", 32'(bus.mem_dout), 32'hBEEF);
      release_bus();

      // controller never acks
      start_rd(25'h0000300);
      step();
      exp_req = 1'b1;
      chk("to_req", 32'(bus.sdr_req), 32'd1);
      for (int i = 0; i < 15; i++) step();
      chk("to_wait_rdy", 32'(bus.ready), 32'd0);
      chk("to_wait_terr", 32'(bus.timeout_err), 32'd0);
      step();
      chk("to_dout", 32'(bus.mem_dout), 32'hFFFF);
      step();
      chk("to_rdy", 32'(bus.ready), 32'd1);
      chk("to_terr", 32'(bus.timeout_err), 32'd1);
      step();
      chk("to_terr_off", 32'(bus.timeout_err), 32'd0);
      release_bus();

      // next read must wait for the late ack before issuing
      start_rd(25'h0000400);
      step();
      step();
      chk("late_noreq", 32'(bus.sdr_req), 32'd1);
      chk("late_rdy", 32'(bus.ready), 32'd0);
      ack(16'hCAFE);
      step();
      exp_req = 1'b0;
      chk("late_req", 32'(bus.sdr_req), 32'd0);
      ack(16'h1357);
      step();
      step();
      chk("late_rd_rdy", 32'(bus.ready), 32'd1);
      chk("late_rd_dout", 32'(bus.mem_dout), 32'h1357);
      release_bus();

      // reread of the same word, then write and reread
      sdram_read("c1", 25'h0000500, 16'h2468);
      start_rd(25'h0000500);
`ifdef CPU_READ_CACHE_EN
      step();
      chk("hit_req", 32'(bus.sdr_req), 32'(exp_req));
      step();
      chk("hit_rdy", 32'(bus.ready), 32'd1);
      chk("hit_dout", 32'(bus.mem_dout), 32'h2468);
      release_bus();
`else
      release_bus();
      sdram_read("c2", 25'h0000500, 16'h2468);
`endif
      start_wr(25'h0000500, 16'h7777, 2'b11, 1'b1);
      step();
      exp_req = ~exp_req;
      chk("cw_req", 32'(bus.sdr_req), 32'(exp_req));
      ack(16'h0000);
      step();
      step();
      chk("cw_rdy", 32'(bus.ready), 32'd1);
      release_bus();
      sdram_read("c3", 25'h0000500, 16'h7777);

      // async reset in BUSY
      start_rd(25'h0000600);
      step();
      exp_req = ~exp_req;
      chk("rb_req", 32'(bus.sdr_req), 32'(exp_req));
      rst = 1'b1;
      bus.mem_rd = 1'b0;
      bus.ram_rom_memrq = 1'b0;
      bus.sdr_ack = 1'b0;
      exp_req = 1'b0;
      step();
      chk("rb_req0", 32'(bus.sdr_req), 32'd0);
      chk("rb_dout0", 32'(bus.mem_dout), 32'd0);
      chk("rb_addr0", 32'(bus.sdr_addr), 32'd0);
      chk("rb_rdy0", 32'(bus.ready), 32'd0);
      rst = 1'b0;
      step();
      sdram_read("rb", 25'h0000701, 16'h0F0F);
      chk("rb_addr", 32'(bus.sdr_addr), 32'h0000700);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
